// File: rtl/aes_pkg.sv
// Shared AES definitions: block size, the InvSubBytes FSM state type and the
// inverse S-box constant table, indexed [row][col] = [byte[7:4]][byte[3:0]].
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } inv_sb_state_t;

   localparam logic [7:0] INV_SBOX [16][16] = '{
      '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb},
      '{8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb},
      '{8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e},
      '{8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25},
      '{8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92},
      '{8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84},
      '{8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06},
      '{8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b},
      '{8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73},
      '{8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e},
      '{8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b},
      '{8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4},
      '{8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f},
      '{8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef},
      '{8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61},
      '{8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d}
   };

endpackage

// File: rtl/aes_inv_subbytes_if.sv
// Block-in / block-out channels of the InvSubBytes engine.
// Handshake: a transfer happens on a rising edge where valid && ready; the source
// holds valid and its payload until that edge, and ready never depends on valid.
interface aes_inv_subbytes_if;
   import aes_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic [AES_BLOCK_BYTES*8-1:0] in_state;
   logic                         out_valid;
   logic                         out_ready;
   logic [AES_BLOCK_BYTES*8-1:0] out_state;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_state
   );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box lookup, addressed by the high (row) and low (col) nibble.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [7:0] sbox_out
);

   assign sbox_out = INV_SBOX[row][col];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box lookup (combinational), shared with the encryption datapath.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);

   localparam logic [7:0] SBOX [16][16] = '{
      '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76},
      '{8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0},
      '{8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15},
      '{8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75},
      '{8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84},
      '{8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf},
      '{8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8},
      '{8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2},
      '{8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73},
      '{8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb},
      '{8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79},
      '{8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08},
      '{8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a},
      '{8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e},
      '{8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf},
      '{8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16}
   };

   assign dout = SBOX[din[7:4]][din[3:0]];

endmodule

// File: rtl/aes_inv_subbytes.sv
// Iterative InvSubBytes engine: LANES bytes of the held block are substituted per cycle.
// Define AES_INV_SUBBYTES_CHECK_EN to add the forward-S-box round-trip check and the err port.
module aes_inv_subbytes
   import aes_pkg::*;
#(
   parameter int LANES = 4
)
(
   input  logic                   clk,
   input  logic                   rst_n,
   aes_inv_subbytes_if.slave      bus,
   output inv_sb_state_t          dbg_state,
   output logic                   busy
`ifdef AES_INV_SUBBYTES_CHECK_EN
   ,
   output logic                   err
`endif
);

   localparam int N       = AES_BLOCK_BYTES / LANES;
   localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
   localparam int GRP_W   = LANES * 8;
   localparam int BLOCK_W = AES_BLOCK_BYTES * 8;

   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_inv_subbytes: LANES must be 1, 2, 4, 8 or 16");
   end

   inv_sb_state_t      fsm_q, fsm_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BLOCK_W-1:0] blk_q, blk_d;
   logic [7:0]         grp_lo;
   logic [GRP_W-1:0]   grp_bits;
   logic [GRP_W-1:0]   sub_bits;
   logic               last_grp;

   // Bit offset of the byte group being substituted this cycle.
   assign grp_lo   = 8'(cnt_q) * 8'(GRP_W);
   assign grp_bits = blk_q[grp_lo +: GRP_W];
   assign last_grp = (cnt_q == CNT_W'(N - 1));

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      aes_inv_sbox u_inv_sbox (
         .row      (grp_bits[8*l+4 +: 4]),
         .col      (grp_bits[8*l   +: 4]),
         .sbox_out (sub_bits[8*l   +: 8])
      );
   end

   always_comb begin
      fsm_d         = fsm_q;
      cnt_d         = cnt_q;
      blk_d         = blk_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               blk_d = bus.in_state;
               cnt_d = '0;
               fsm_d = BUSY;
            end
         end
         BUSY: begin
            busy                   = 1'b1;
            blk_d[grp_lo +: GRP_W] = sub_bits;
            if (last_grp) begin
               cnt_d = '0;
               fsm_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               fsm_d = IDLE;
            end
         end
         default: begin
            fsm_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= IDLE;
         cnt_q <= '0;
         blk_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         cnt_q <= cnt_d;
         blk_q <= blk_d;
      end
   end

   // The result is the state register itself, so it cannot move while DONE waits.
   assign bus.out_state = blk_q;
   assign dbg_state     = fsm_q;

`ifdef AES_INV_SUBBYTES_CHECK_EN
   logic [GRP_W-1:0] fwd_bits;
   logic [LANES-1:0] lane_bad;
   logic             err_q;

   for (genvar l = 0; l < LANES; l++) begin : g_check
      aes_sbox u_fwd_sbox (
         .din  (sub_bits[8*l +: 8]),
         .dout (fwd_bits[8*l +: 8])
      );
      assign lane_bad[l] = (fwd_bits[8*l +: 8] != grp_bits[8*l +: 8]);
   end

   // Sticky until reset; flagged on the same edge that writes the offending byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (fsm_q == BUSY && |lane_bad) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_aes_inv_subbytes.sv
// Bench for aes_inv_subbytes: LANES=16/4/1 instances share one stimulus stream and are
// checked against fixed vectors and a GF(2^8)-derived inverse S-box model.
module tb_aes_inv_subbytes;
   import aes_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;

   always #5 clk = ~clk;

   aes_inv_subbytes_if if16 ();
   aes_inv_subbytes_if if4 ();
   aes_inv_subbytes_if if1 ();

   assign if16.in_valid  = in_valid;
   assign if16.in_state  = in_state;
   assign if16.out_ready = out_ready;
   assign if4.in_valid   = in_valid;
   assign if4.in_state   = in_state;
   assign if4.out_ready  = out_ready;
   assign if1.in_valid   = in_valid;
   assign if1.in_state   = in_state;
   assign if1.out_ready  = out_ready;

   inv_sb_state_t st [3];
   logic          busy_v [3];
   logic          ov [3];
   logic          ir [3];
   logic [127:0]  os [3];
`ifdef AES_INV_SUBBYTES_CHECK_EN
   logic          err_v [3];
`endif

   assign ov[0] = if16.out_valid;
   assign ov[1] = if4.out_valid;
   assign ov[2] = if1.out_valid;
   assign ir[0] = if16.in_ready;
   assign ir[1] = if4.in_ready;
   assign ir[2] = if1.in_ready;
   assign os[0] = if16.out_state;
   assign os[1] = if4.out_state;
   assign os[2] = if1.out_state;

   aes_inv_subbytes #(.LANES(16)) u16 (
      .clk (clk), .rst_n (rst_n), .bus (if16.slave), .dbg_state (st[0]), .busy (busy_v[0])
`ifdef AES_INV_SUBBYTES_CHECK_EN
      , .err (err_v[0])
`endif
   );

   aes_inv_subbytes #(.LANES(4)) u4 (
      .clk (clk), .rst_n (rst_n), .bus (if4.slave), .dbg_state (st[1]), .busy (busy_v[1])
`ifdef AES_INV_SUBBYTES_CHECK_EN
      , .err (err_v[1])
`endif
   );

   aes_inv_subbytes #(.LANES(1)) u1 (
      .clk (clk), .rst_n (rst_n), .bus (if1.slave), .dbg_state (st[2]), .busy (busy_v[2])
`ifdef AES_INV_SUBBYTES_CHECK_EN
      , .err (err_v[2])
`endif
   );

   localparam int LANES_OF [3] = '{16, 4, 1};
   localparam int EXP_LAT  [3] = '{1, 4, 16};

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: InvSubBytes(x) = GF(2^8) inverse of the inverse affine transform of x.
   logic [7:0] ref_inv [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   task automatic init_model();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] t;
         logic [7:0] inv;
         t   = affine_inv(8'(x));
         inv = 8'h00;
         for (int c = 1; c < 256; c++) begin
            if (t != 8'h00 && gmul(t, 8'(c)) == 8'h01) inv = 8'(c);
         end
         ref_inv[x] = inv;
      end
   endtask

   function automatic logic [127:0] ref_block(input logic [127:0] blk);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_inv[blk[8*i +: 8]];
      return r;
   endfunction

   int           lat [3];
   logic [127:0] res [3];

   // Offers one block to all three engines, then records each one's latency and result.
   task automatic run_block(input logic [127:0] blk);
      @(negedge clk);
      in_state = blk;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         lat[k] = -1;
         res[k] = '0;
      end
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (lat[k] < 0 && ov[k]) begin
               lat[k] = j;
               res[k] = os[k];
            end
         end
         if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      end
   endtask

   task automatic release_out(input int delay);
      repeat (delay) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic check_results(input string tag, input logic [127:0] exp);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_data_L%0d", tag, LANES_OF[k]), res[k], exp);
         chk($sformatf("%s_lat_L%0d", tag, LANES_OF[k]), 128'(lat[k]), 128'(EXP_LAT[k]));
      end
   endtask

   task automatic check_idle_reset(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s_flags_L%0d", tag, LANES_OF[k]), 128'({ir[k], ov[k], busy_v[k]}), 128'(3'b100));
         chk($sformatf("%s_data_L%0d", tag, LANES_OF[k]), os[k], 128'h0);
         chk($sformatf("%s_state_L%0d", tag, LANES_OF[k]), 128'(st[k]), 128'(IDLE));
`ifdef AES_INV_SUBBYTES_CHECK_EN
         chk($sformatf("%s_err_L%0d", tag, LANES_OF[k]), 128'(err_v[k]), 128'h0);
`endif
      end
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   vec_t vecs [5];

   initial begin : watchdog
      #2000000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : main
      vecs[0] = '{din: {16{8'h63}}, dout: 128'h0};
      vecs[1] = '{din: 128'h76ABD7FE2B670130C56F6BF27B777C63, dout: 128'h0F0E0D0C0B0A09080706050403020100};
      vecs[2] = '{din: 128'h636363636363636363636301ED531600, dout: 128'h0000000000000000000000095350FF52};
      vecs[3] = '{din: {16{8'h00}}, dout: {16{8'h52}}};
      vecs[4] = '{din: {16{8'hFF}}, dout: {16{8'h7D}}};

      init_model();

      // Reset values while held in reset and just after release.
      repeat (3) @(negedge clk);
      check_idle_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle_reset("post_rst");

      for (int v = 0; v < 5; v++) begin
         run_block(vecs[v].din);
         check_results($sformatf("vec%0d", v), vecs[v].dout);
         release_out(0);
      end

      // Backpressure: DONE held with in_valid pulsing; nothing may change or be accepted.
      run_block(vecs[1].din);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_data_L%0d", LANES_OF[k]), os[k], vecs[1].dout);
            chk($sformatf("bp_flags_L%0d", LANES_OF[k]), 128'({ir[k], ov[k], busy_v[k]}), 128'(3'b010));
         end
         in_valid = (c % 2 == 0);
         in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("bp_release_L%0d", LANES_OF[k]), 128'({ir[k], ov[k], busy_v[k]}), 128'(3'b100));
      end

      // Reset mid-BUSY: the LANES=1 engine is in its 7th BUSY cycle.
      @(negedge clk);
      in_state = vecs[2].din;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("midbusy_pre_L1", 128'(busy_v[2]), 128'h1);
      rst_n = 1'b0;
      #1;
      check_idle_reset("midbusy_rst");
      @(negedge clk);
      rst_n = 1'b1;
      run_block(vecs[2].din);
      check_results("after_rst", vecs[2].dout);
      release_out(0);

      // Random blocks against the GF(2^8) model, with random output stall lengths.
      for (int b = 0; b < 256; b++) begin
         logic [127:0] blk;
         blk = {$urandom(), $urandom(), $urandom(), $urandom()};
         run_block(blk);
         check_results($sformatf("rand%0d", b), ref_block(blk));
         release_out($urandom_range(0, 3));
      end

`ifdef AES_INV_SUBBYTES_CHECK_EN
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("err_final_L%0d", LANES_OF[k]), 128'(err_v[k]), 128'h0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_subbytes.md
# aes_inv_subbytes

Iterative InvSubBytes engine for the AES decryption datapath. It accepts one 128-bit state over a valid/ready handshake. It substitutes every byte through the AES inverse S-box, LANES bytes per cycle, then presents the 128-bit result on a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse round and is the decryption counterpart of the forward SubBytes lookup.

## Interface
- LANES, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16. Any other value is an elaboration error.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_state carries a block to process.
- in_ready  output  1  engine can accept a block.
- in_state  input  128  input block. Byte i = in_state[8*i+7:8*i].
- out_valid  output  1  out_state holds a finished block.
- out_ready  input  1  consumer takes the block.
- out_state  output  128  substituted block, same byte mapping as in_state.
- busy  output  1  high while in BUSY.
- err  output  1  only present when AES_INV_SUBBYTES_CHECK_EN is defined.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE
  - in_ready=1.
  - On in_valid && in_ready: load in_state into the state register, clear the byte-group counter cnt, go to BUSY.
- BUSY
  - Each cycle, replace bytes cnt*LANES through cnt*LANES+LANES-1 with inv_sbox(byte). For each byte, row = byte[7:4] and col = byte[3:0].
  - Increment cnt.
  - When cnt = 16/LANES-1, the final group is written and the FSM goes to DONE.
- DONE
  - out_valid=1. out_state is driven directly from the state register and stays stable.
  - On out_ready, go to IDLE.
  - While out_ready=0, hold DONE indefinitely with no change to any output.
- in_ready is 1 only in IDLE. A block is never accepted while another is in flight or waiting for output; in_valid in BUSY or DONE is ignored.
- in_valid and out_ready are independent. No combinational path exists from out_ready to in_ready.
- cnt width is $clog2(16/LANES), with a minimum of 1 bit. cnt never wraps while in BUSY.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_state=0, err=0, state=IDLE, cnt=0.
- rst_n asserted at any point, including mid-BUSY or during DONE, immediately forces the reset values. The partial block is discarded.
- N = 16/LANES.
- Input handshake at edge k → BUSY during cycles k+1 through k+N. out_valid goes high after edge k+N.
  - LANES=16: 1 cycle.
  - LANES=4: 4 cycles.
  - LANES=1: 16 cycles.
- Output handshake at edge m → in_ready=1 in cycle m+1. The next block can be accepted no earlier than edge m+1.
- Maximum throughput is one block per N+2 cycles.

## Configuration
- Macro: AES_INV_SUBBYTES_CHECK_EN.
- Defined:
  - Each substituted byte is passed back through a forward S-box and compared against the original byte.
  - Any mismatch sets err on the same edge that writes that byte.
  - err is sticky and is cleared only by rst_n.
  - Latency is unchanged.
- Undefined: no forward S-box, no err port, no check logic.

## Structure
- Package aes_pkg holds:
  - AES_BLOCK_BYTES = 16.
  - The FSM enum type inv_sb_state_t {IDLE, BUSY, DONE}.
  - The 256-entry inverse S-box constant table, indexed [row][col].
- Sub-module aes_inv_sbox: combinational lookup with inputs row[3:0] and col[3:0] and output sbox_out[7:0]. Instantiate it LANES times.
- Under AES_INV_SUBBYTES_CHECK_EN, also instantiate the existing forward S-box LANES times.

## Test plan
- LANES=16, all 16 input bytes 0x63 → out_state all 0x00; out_valid high 1 cycle after the accept edge.
- LANES=4, input bytes 0..15 = 63 7C 77 7B F2 6B 6F C5 30 01 67 2B FE D7 AB 76 → output bytes 0..15 = 00 01 02 … 0F; out_valid high 4 cycles after the accept edge.
- LANES=1, input bytes 00,16,53,ED,01 with the rest 0x63 → output bytes 52,FF,50,53,09 with the rest 0x00; latency 16 cycles.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while pulsing in_valid → out_state stable, in_ready=0, no second block accepted. Raise out_ready → in_ready=1 on the next cycle.
- Assert rst_n=0 mid-BUSY (LANES=1, cycle 7) → out_valid=0, busy=0, in_ready=1 immediately. A fresh block after release processes correctly.
- With AES_INV_SUBBYTES_CHECK_EN, run 256 random blocks → err stays 0 and every result matches the reference model.
